// File: rtl/nonce_result_scan_if.sv
// Shared memory port between the nonce result scanner and its memory.
interface nonce_result_scan_if;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic          mem_clk;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data;

   modport master (
      output mem_clk,
      output mem_we,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_clk,
      input  mem_we,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES H0 words from memory, tracks minimum and target hits,
// then writes a two-word summary (min_hash, packed flags) back to memory.
module nonce_result_scan #(
   parameter int unsigned NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] input_addr,
   input  logic [15:0] result_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [5:0]  hit_count,
   output logic [4:0]  first_hit_nonce,
   output logic [4:0]  best_nonce,
   output logic [31:0] min_hash,
   nonce_result_scan_if.master mem
);
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;
   localparam int unsigned CW = 6;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_READ, S_WRITE0, S_WRITE1, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          done_q, done_d;
   logic          found_q, found_d;
   logic [CW-1:0] hit_count_q, hit_count_d;
   logic [IW-1:0] first_q, first_d;
   logic [IW-1:0] best_q, best_d;
   logic [DW-1:0] min_q, min_d;

   logic word_lt_min, word_hit, more_addr, last_word;

   // Memory shares the block clock.
   assign mem.mem_clk        = clk;
   assign mem.mem_we         = mem_we_q;
   assign mem.mem_addr       = mem_addr_q;
   assign mem.mem_write_data = mem_wdata_q;

   assign done            = done_q;
   assign found           = found_q;
   assign hit_count       = hit_count_q;
   assign first_hit_nonce = first_q;
   assign best_nonce      = best_q;
   assign min_hash        = min_q;

   // Compare terms for the word arriving this cycle; address lookahead uses offsets so base wrap is harmless.
   assign word_lt_min = mem.mem_read_data < min_q;
   assign word_hit    = mem.mem_read_data < target;
   assign more_addr   = (CW'(idx_q) + CW'(2)) < CW'(NUM_NONCES);
   assign last_word   = idx_q == IW'(NUM_NONCES - 1);

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         hit_count_q <= '0;
         first_q     <= '0;
         best_q      <= '0;
         min_q       <= '1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         found_q     <= found_d;
         hit_count_q <= hit_count_d;
         first_q     <= first_d;
         best_q      <= best_d;
         min_q       <= min_d;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      found_d     = found_q;
      hit_count_d = hit_count_q;
      first_d     = first_q;
      best_d      = best_q;
      min_d       = min_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               mem_we_d = 1'b0;
               done_d   = 1'b1;
            end
            if (start) begin
               mem_addr_d  = input_addr;
               idx_d       = '0;
               mem_we_d    = 1'b0;
               done_d      = 1'b0;
               found_d     = 1'b0;
               hit_count_d = '0;
               first_d     = '0;
               best_d      = '0;
               min_d       = '1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_addr_d = input_addr + AW'(1);
            state_d    = S_READ;
         end
         S_READ: begin
            if (more_addr) mem_addr_d = input_addr + AW'(idx_q) + AW'(2);
            if (word_lt_min) begin
               min_d  = mem.mem_read_data;
               best_d = idx_q;
            end
            if (word_hit) begin
               hit_count_d = hit_count_q + CW'(1);
               if (!found_q) begin
                  found_d = 1'b1;
                  first_d = idx_q;
               end
            end
            if (last_word) state_d = S_WRITE0;
            else           idx_d   = idx_q + IW'(1);
         end
         S_WRITE0: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = result_addr;
            mem_wdata_d = min_q;
            state_d     = S_WRITE1;
         end
         S_WRITE1: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = result_addr + AW'(1);
            mem_wdata_d = {found_q, 9'd0, hit_count_q, 3'd0, first_q, 3'd0, best_q};
            state_d     = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_nonce_result_scan.sv
// Self-checking bench: random and directed scans against a behavioural model.
module tb_nonce_result_scan;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, start1 = 1'b0;
   logic [15:0] input_addr = '0, result_addr = '0;
   logic [31:0] target = '0;
   logic        done, found, done1, found1;
   logic [5:0]  hit_count, hit_count1;
   logic [4:0]  first_hit_nonce, best_nonce, first_hit_nonce1, best_nonce1;
   logic [31:0] min_hash, min_hash1;

   logic        ld_we = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [31:0] mem  [65536];
   logic [31:0] mem1 [65536];
   logic [31:0] h0   [32];

   int errors = 0;
   int checks = 0;

   nonce_result_scan_if mif ();
   nonce_result_scan_if mif1 ();

   nonce_result_scan #(.NUM_NONCES(N)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .input_addr(input_addr), .result_addr(result_addr), .target(target),
      .done(done), .found(found), .hit_count(hit_count),
      .first_hit_nonce(first_hit_nonce), .best_nonce(best_nonce),
      .min_hash(min_hash), .mem(mif.master)
   );

   nonce_result_scan #(.NUM_NONCES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .input_addr(input_addr), .result_addr(result_addr), .target(target),
      .done(done1), .found(found1), .hit_count(hit_count1),
      .first_hit_nonce(first_hit_nonce1), .best_nonce(best_nonce1),
      .min_hash(min_hash1), .mem(mif1.master)
   );

   always #5 clk = ~clk;

   // Synchronous memories; the bench load port writes both.
   always @(posedge clk) begin
      if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_write_data;
      else if (ld_we) mem[ld_addr] <= ld_data;
      mif.mem_read_data <= mem[mif.mem_addr];
      if (mif1.mem_we) mem1[mif1.mem_addr] <= mif1.mem_write_data;
      else if (ld_we) mem1[ld_addr] <= ld_data;
      mif1.mem_read_data <= mem1[mif1.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_we = 1'b0;
   endtask

   task automatic load_h0(input logic [15:0] ia);
      for (int i = 0; i < N; i++) load_word(ia + 16'(i), h0[i]);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ":done"},  32'(done), 32'd0);
      chk({tag, ":found"}, 32'(found), 32'd0);
      chk({tag, ":hits"},  32'(hit_count), 32'd0);
      chk({tag, ":first"}, 32'(first_hit_nonce), 32'd0);
      chk({tag, ":best"},  32'(best_nonce), 32'd0);
      chk({tag, ":min"},   min_hash, 32'hFFFFFFFF);
      chk({tag, ":we"},    32'(mif.mem_we), 32'd0);
      chk({tag, ":addr"},  32'(mif.mem_addr), 32'd0);
      chk({tag, ":wdata"}, mif.mem_write_data, 32'd0);
   endtask

   // Runs one full scan of h0[0..N-1] (already in memory at ia); stray>0 pulses start at that edge.
   task automatic run_scan(input string tag, input logic [15:0] ia, input logic [15:0] ra,
                           input logic [31:0] tgt, input int stray);
      logic [31:0] mn, w1;
      logic [4:0]  bst, fh;
      logic [5:0]  hc;
      logic        fnd;
      int          de, wc;
      mn = '1; bst = '0; fh = '0; hc = '0; fnd = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (h0[i] < mn) begin mn = h0[i]; bst = 5'(i); end
         if (h0[i] < tgt) begin
            if (!fnd) fh = 5'(i);
            fnd = 1'b1;
            hc  = hc + 6'd1;
         end
      end
      w1 = {fnd, 9'd0, hc, 3'd0, fh, 3'd0, bst};

      @(negedge clk);
      input_addr = ia; result_addr = ra; target = tgt; start = 1'b1;
      @(posedge clk); #1;
      chk({tag, ":done_fall"}, 32'(done), 32'd0);
      de = 0; wc = 0;
      for (int e = 1; e <= 60 && de == 0; e++) begin
         @(negedge clk);
         start = (e == stray);
         @(posedge clk); #1;
         if (mif.mem_we) wc++;
         if (done) de = e;
      end
      start = 1'b0;
      chk({tag, ":done_edge"}, 32'(de), 32'(N + 4));
      chk({tag, ":we_cycles"}, 32'(wc), 32'd2);
      chk({tag, ":found"}, 32'(found), 32'(fnd));
      chk({tag, ":hits"},  32'(hit_count), 32'(hc));
      chk({tag, ":first"}, 32'(first_hit_nonce), 32'(fh));
      chk({tag, ":best"},  32'(best_nonce), 32'(bst));
      chk({tag, ":min"},   min_hash, mn);
      chk({tag, ":word0"}, mem[ra], mn);
      chk({tag, ":word1"}, mem[ra + 16'd1], w1);
   endtask

   task automatic rand_h0();
      for (int i = 0; i < N; i++) h0[i] = $urandom >> $urandom_range(0, 8);
   endtask

   initial begin
      logic [15:0] ia;
      int de1;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("mem_clk", 32'(mif.mem_clk), 32'd1);

      // All words above target.
      for (int i = 0; i < N; i++) h0[i] = 32'h10000000 + 32'(i);
      load_h0(16'h0100);
      run_scan("above", 16'h0100, 16'h0800, 32'h00000100, 0);
      chk("above:w1_const", mem[16'h0801], 32'h00000000);

      // Mixed hits, also back-to-back from DONE.
      for (int i = 0; i < N; i++) h0[i] = 32'hFFFFFFFF;
      h0[3] = 32'h000000FF;
      h0[9] = 32'h00000010;
      load_h0(16'h0100);
      run_scan("mixed", 16'h0100, 16'h0800, 32'h00000100, 0);
      chk("mixed:w1_const", mem[16'h0801], 32'h80020309);

      // Ties at the target boundary.
      for (int i = 0; i < N; i++) h0[i] = 32'h00000100;
      load_h0(16'h0100);
      run_scan("ties", 16'h0100, 16'h0800, 32'h00000100, 0);

      // Unique minimum on the last word.
      rand_h0();
      for (int i = 0; i < N - 1; i++) h0[i] = h0[i] | 32'h1;
      h0[N-1] = 32'h0;
      load_h0(16'h2000);
      run_scan("lastmin", 16'h2000, 16'h2100, $urandom, 0);
      chk("lastmin:best_const", 32'(best_nonce), 32'(N - 1));

      // Reset during READ with idx=7: no summary may land at result_addr.
      rand_h0();
      load_h0(16'h3000);
      load_word(16'h3100, 32'hDEADBEEF);
      load_word(16'h3101, 32'hCAFEF00D);
      @(negedge clk);
      input_addr = 16'h3000; result_addr = 16'h3100; target = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset("midreset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("midreset:word0_kept", mem[16'h3100], 32'hDEADBEEF);
      chk("midreset:word1_kept", mem[16'h3101], 32'hCAFEF00D);
      chk("midreset:done_low", 32'(done), 32'd0);
      run_scan("restart", 16'h3000, 16'h3100, 32'h08000000, 0);

      // Start pulse during READ is ignored.
      rand_h0();
      load_h0(16'h4000);
      run_scan("stray", 16'h4000, 16'h4100, $urandom >> 2, 6);

      // Base address wrap.
      rand_h0();
      load_h0(16'hFFF8);
      run_scan("wrap", 16'hFFF8, 16'h0500, $urandom >> 1, 0);

      // Random scans.
      for (int r = 0; r < 4; r++) begin
         rand_h0();
         ia = 16'($urandom);
         load_h0(ia);
         run_scan($sformatf("rand%0d", r), ia, ia + 16'h0100, $urandom >> $urandom_range(0, 4), 0);
      end

      // Single-word instance.
      load_word(16'h0200, 32'h00001234);
      @(negedge clk);
      input_addr = 16'h0200; result_addr = 16'h0300; target = 32'h00001235; start1 = 1'b1;
      @(posedge clk);
      de1 = 0;
      for (int e = 1; e <= 40 && de1 == 0; e++) begin
         @(negedge clk);
         start1 = 1'b0;
         @(posedge clk); #1;
         if (done1) de1 = e;
      end
      chk("n1:done_edge", 32'(de1), 32'd5);
      chk("n1:min", min_hash1, 32'h00001234);
      chk("n1:hits", 32'(hit_count1), 32'd1);
      chk("n1:word0", mem1[16'h0300], 32'h00001234);
      chk("n1:word1", mem1[16'h0301], 32'h80010000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/nonce_result_scan.md
# nonce_result_scan

Post-processing stage that sits directly downstream of the bitcoin hash engine. After the hash engine writes its NUM_NONCES per-nonce H0 words to memory, this block reads them back through the shared memory port and compares each against a difficulty target. It finds the minimum H0 and the first nonce that meets the target, then writes a two-word summary back to memory for the host.

## Interface
- NUM_NONCES, 16, number of consecutive H0 words to scan (legal range 1..32); word i corresponds to nonce i
- clk  in  1  sole clock; memory is clocked on the same edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- input_addr  in  16  base address of the H0 words (hash engine output_addr)
- result_addr  in  16  base address of the 2-word summary
- target  in  32  difficulty target; H0 hits when H0 < target (unsigned, strict)
- done  out  1  high from scan completion until the next accepted start
- mem_clk  out  1  equals clk
- mem_we  out  1  registered write enable
- mem_addr  out  16  registered address
- mem_write_data  out  32  registered write data
- mem_read_data  in  32  synchronous read data
- found  out  1  at least one hit
- hit_count  out  6  number of hits
- first_hit_nonce  out  5  lowest index that hit (0 if none)
- best_nonce  out  5  index of minimum H0; ties keep the lower index
- min_hash  out  32  minimum H0 scanned

## Operation
- States: IDLE, ISSUE, READ, WRITE0, WRITE1, DONE.
- **IDLE/DONE + start:**
  - mem_addr<=input_addr; idx<=0; mem_we<=0; done<=0.
  - Clear found, hit_count, first_hit_nonce, best_nonce to 0 and min_hash to FFFFFFFF.
  - Go to ISSUE.
- **ISSUE:** mem_addr<=input_addr+1; go to READ. The cycle covers the one-cycle memory latency.
- **READ:** one word per cycle; word idx is sampled on the current edge.
  - Issue the next address while input_addr+idx+2 < input_addr+NUM_NONCES; otherwise hold mem_addr.
  - If the word < min_hash: min_hash<=word; best_nonce<=idx.
  - If the word < target: hit_count++.
  - If the word < target and this is the first hit: found<=1; first_hit_nonce<=idx.
  - Hit and min updates use the current word combinationally, so the last word is included with no extra cycle.
  - After sampling idx=NUM_NONCES-1, go to WRITE0.
- **WRITE0:** mem_we<=1; mem_addr<=result_addr; mem_write_data<=min_hash, with the final update from the last word already applied.
- **WRITE1:** mem_we<=1; mem_addr<=result_addr+1; mem_write_data<={found, 9'b0, hit_count, 3'b0, first_hit_nonce, 3'b0, best_nonce}. Bit placement:
  - bit 31: found
  - bits 21:16: hit_count
  - bits 12:8: first_hit_nonce
  - bits 4:0: best_nonce
- **DONE:** mem_we<=0; done<=1. Result outputs hold until the next start.
- **Arithmetic and width rules:**
  - Address adds wrap modulo 2^16.
  - Compares are 32-bit unsigned.
  - hit_count saturates naturally; it never exceeds 32.
- start outside IDLE/DONE is ignored.
- **Reset (any state, including mid-scan or mid-write):**
  - Immediate return to IDLE.
  - Outputs go to: done 0, mem_we 0, mem_addr 0, mem_write_data 0, found 0, hit_count 0, first_hit_nonce 0, best_nonce 0, min_hash FFFFFFFF.
  - No further memory writes occur.

## Timing
- Let E0 be the edge that accepts start.
  - mem_addr=input_addr+k is registered at edge Ek.
  - Word k is sampled at edge E(k+2).
- Last word is sampled at E(N+1), where N=NUM_NONCES.
- Writes:
  - WRITE0 outputs are registered at E(N+2); memory commits at E(N+3).
  - WRITE1 outputs are registered at E(N+3); memory commits at E(N+4).
- done rises at E(N+4); for N=16, that is 20 edges after start.
- mem_we is high for exactly 2 cycles per scan and is never high during READ.
- done falls on the edge that accepts the next start.

## Test plan
- **All words above target:** N=16, H0[i]=0x10000000+i, target=0x00000100 -> found=0, hit_count=0, min_hash=0x10000000, best_nonce=0, word1=0x00000000; done rises at E20.
- **Mixed hits:** H0[3]=0x000000FF, H0[9]=0x00000010, others 0xFFFFFFFF, target=0x00000100 -> found=1, hit_count=2, first_hit_nonce=3, best_nonce=9, mem[result_addr]=0x00000010, mem[result_addr+1]=0x80020309.
- **Ties and boundary:** all H0=0x00000100, target=0x00000100 -> no hits (strict compare), best_nonce=0, min_hash=0x00000100.
- **Last-word minimum and N=1:** last word is the unique minimum -> best_nonce=N-1 with no extra cycle. With NUM_NONCES=1, done rises at E5.
- **Reset and restart:**
  - Assert reset_n low during READ (idx=7) -> all outputs at reset values; no write reaches result_addr.
  - A subsequent start gives a clean full scan.
- **Back-to-back and ignored start:**
  - A start pulse during READ is ignored (counts are unchanged).
  - A start in DONE clears done on that edge and the second scan's results overwrite the first.
  - input_addr=0xFFF8 wraps correctly to 0x0007.
